// File: rtl/truth_table_checker.sv
// Exhaustively exercises an external 2-input gate with the four input vectors
// and compares its output against the selected logic function.
module truth_table_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic [1:0] state_dbg
);

  // Handshake: start is accepted only in IDLE; busy is high while vectors are
  // applied; done pulses for one cycle with pass/err_count/fail_vec already valid.
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [3:0] settle_cnt, settle_n;
  logic [2:0] op_q, op_n;
  logic [2:0] err_n;
  logic [3:0] fail_n;
  logic       pass_n;
  logic       mismatch;
  logic [2:0] err_tmp;
  logic [3:0] fail_tmp;

  function automatic logic expected_y(input logic [2:0] f, input logic a, input logic b);
    case (f)
      3'd0:    expected_y = a & b;
      3'd1:    expected_y = a | b;
      3'd2:    expected_y = ~(a & b);
      3'd3:    expected_y = ~(a | b);
      3'd4:    expected_y = a ^ b;
      3'd5:    expected_y = ~(a ^ b);
      default: expected_y = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= 4'd0;
      op_q       <= 3'd0;
      err_count  <= 3'd0;
      fail_vec   <= 4'd0;
      pass       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      settle_cnt <= settle_n;
      op_q       <= op_n;
      err_count  <= err_n;
      fail_vec   <= fail_n;
      pass       <= pass_n;
    end
  end

  // Gate inputs come straight from idx, gated so they read 0 outside a run.
  assign busy      = (state == APPLY) || (state == SAMPLE);
  assign done      = (state == DONE);
  assign dut_a     = busy & idx[1];
  assign dut_b     = busy & idx[0];
  assign state_dbg = state;

  assign mismatch = (dut_y != expected_y(op_q, dut_a, dut_b));
  assign err_tmp  = err_count + {2'b00, mismatch};
  assign fail_tmp = fail_vec | ({3'b000, mismatch} << idx);

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    settle_n = settle_cnt;
    op_n     = op_q;
    err_n    = err_count;
    fail_n   = fail_vec;
    pass_n   = pass;
    case (state)
      IDLE: begin
        if (start) begin
          if (op <= 3'd5) begin
            op_n     = op;
            err_n    = 3'd0;
            fail_n   = 4'd0;
            pass_n   = 1'b0;
            idx_n    = 2'd0;
            settle_n = 4'd0;
            state_n  = APPLY;
          end else begin
            // Unsupported function: report every vector as failed without testing.
            err_n   = 3'd4;
            fail_n  = 4'hF;
            pass_n  = 1'b0;
            state_n = DONE;
          end
        end
      end
      APPLY: begin
        if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
          settle_n = 4'd0;
          state_n  = SAMPLE;
        end else begin
          settle_n = settle_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        err_n  = err_tmp;
        fail_n = fail_tmp;
        if (idx == 2'd3) begin
          pass_n  = (err_tmp == 3'd0);
          state_n = DONE;
        end else begin
          idx_n   = idx + 2'd1;
          state_n = APPLY;
        end
      end
      DONE: begin
        idx_n   = 2'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a table of runs against a modelled
// gate, plus hand-written sequences for start re-pulse and mid-run reset.
module tb_truth_table_checker;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic       dut_a, dut_b, dut_y;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [1:0] state_dbg;

  int gate_mode = 0;  // 0 AND, 1 stuck-at-0, 2 XOR
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] op_v;
    int         gm;
    bit         repulse;
    logic       exp_pass;
    logic [2:0] exp_err;
    logic [3:0] exp_fail;
    int         exp_busy;
  } vec_t;

  vec_t vecs[$];

  truth_table_checker #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (gate_mode)
      1:       dut_y = 1'b0;
      2:       dut_y = dut_a ^ dut_b;
      default: dut_y = dut_a & dut_b;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_outs"}, {dut_a, dut_b, busy, done, pass, err_count, fail_vec}, 0);
  endtask

  task automatic run(input vec_t v, input int id);
    int  busy_cnt, done_cnt, ab_bad, post;
    bit  seen;
    logic [2:0] r_err;
    logic [3:0] r_fail;
    logic r_pass;
    int vi;
    busy_cnt = 0; done_cnt = 0; ab_bad = 0; post = 0; seen = 0;
    r_err = '0; r_fail = '0; r_pass = 1'b0;
    gate_mode = v.gm;
    @(negedge clk);
    op = v.op_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (busy) begin
        vi = busy_cnt / (S + 1);
        if (dut_a !== vi[1] || dut_b !== vi[0]) ab_bad++;
        busy_cnt++;
      end else if (dut_a !== 1'b0 || dut_b !== 1'b0) begin
        ab_bad++;
      end
      if (done) begin
        done_cnt++;
        if (!seen) begin
          r_pass = pass; r_err = err_count; r_fail = fail_vec;
        end
        seen = 1'b1;
      end else if (seen) begin
        post++;
      end
      if (v.repulse && busy_cnt == 5 && busy) begin
        start = 1'b1;
        op = 3'd2;
      end else begin
        start = 1'b0;
      end
      if (post == 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL run%0d_done_timeout: got no done expected one", id);
    end
    check($sformatf("run%0d_busy_len", id), busy_cnt, v.exp_busy);
    check($sformatf("run%0d_done_pulses", id), done_cnt, 1);
    check($sformatf("run%0d_ab_seq_errs", id), ab_bad, 0);
    check($sformatf("run%0d_pass", id), r_pass, v.exp_pass);
    check($sformatf("run%0d_err_count", id), r_err, v.exp_err);
    check($sformatf("run%0d_fail_vec", id), r_fail, v.exp_fail);
    check($sformatf("run%0d_hold", id), {pass, err_count, fail_vec},
          {v.exp_pass, v.exp_err, v.exp_fail});
  endtask

  initial begin
    int vcnt, dcnt;
    //          op    gm  rep  pass err   fail     busy
    vecs.push_back('{3'd0, 0, 0, 1'b1, 3'd0, 4'b0000, 12});
    vecs.push_back('{3'd0, 1, 0, 1'b0, 3'd1, 4'b1000, 12});
    vecs.push_back('{3'd3, 0, 0, 1'b0, 3'd2, 4'b1001, 12});
    vecs.push_back('{3'd1, 0, 0, 1'b0, 3'd2, 4'b0110, 12});
    vecs.push_back('{3'd2, 0, 0, 1'b0, 3'd4, 4'b1111, 12});
    vecs.push_back('{3'd4, 0, 0, 1'b0, 3'd3, 4'b1110, 12});
    vecs.push_back('{3'd5, 0, 0, 1'b0, 3'd1, 4'b0001, 12});
    vecs.push_back('{3'd4, 2, 0, 1'b1, 3'd0, 4'b0000, 12});
    vecs.push_back('{3'd0, 0, 1, 1'b1, 3'd0, 4'b0000, 12});
    vecs.push_back('{3'd7, 0, 0, 1'b0, 3'd4, 4'hF,    0});
    vecs.push_back('{3'd6, 0, 0, 1'b0, 3'd4, 4'hF,    0});
    vecs.push_back('{3'd5, 1, 0, 1'b0, 3'd2, 4'b1001, 12});

    // Clock/reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    check("reset_state", state_dbg, 0);
    rst_n = 1'b1;

    // First start after reset is accepted normally (row 0).
    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

    // Mid-run reset during vector 2, asserted between clock edges.
    gate_mode = 0;
    @(negedge clk);
    op = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vcnt = 0;
    for (int cyc = 0; cyc < 40 && vcnt < 2 * (S + 1) + 1; cyc++) begin
      if (busy) vcnt++;
      if (vcnt < 2 * (S + 1) + 1) @(negedge clk);
    end
    check("mid_reset_in_vec2", {dut_a, dut_b, busy}, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero("mid_reset");
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("mid_reset_no_done", dcnt, 0);
    rst_n = 1'b1;
    run('{3'd0, 0, 0, 1'b1, 3'd0, 4'b0000, 12}, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled bench expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, SHALL set the number of cycles each input vector is held before dut_y is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a test run when high in IDLE.
REQ-005 op  input  3  SHALL select the expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 invalid.
REQ-006 dut_a  output  1  SHALL drive the first input of the 2-input gate under test.
REQ-007 dut_b  output  1  SHALL drive the second input of the 2-input gate under test.
REQ-008 dut_y  input  1  SHALL carry the output of the gate under test.
REQ-009 busy  output  1  SHALL be high while a run is in progress.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking the end of a run.
REQ-011 pass  output  1  SHALL be high when the last run found no mismatches.
REQ-012 err_count  output  3  SHALL report the mismatch count of the last run (0..4).
REQ-013 fail_vec  output  4  SHALL set bit i when vector i mismatched in the last run.

Function
REQ-014 The FSM SHALL have the states IDLE, APPLY, SAMPLE and DONE.
REQ-015 In IDLE with start=1 and a valid op, the block SHALL latch op, clear err_count, fail_vec and pass, set vector index idx=0, and go to APPLY on the next edge.
REQ-016 Vector i SHALL drive dut_a=idx[1] and dut_b=idx[0], giving the order 00, 01, 10, 11.
REQ-017 APPLY SHALL hold the current vector for exactly SETTLE_CYCLES cycles, counted by a 4-bit settle counter.
REQ-018 SAMPLE SHALL last one cycle and SHALL compare dut_y with expected(op_latched, dut_a, dut_b).
- On mismatch, it SHALL set fail_vec[idx] and increment err_count by 1.
REQ-019 After SAMPLE, if idx<3 the block SHALL increment idx and return to APPLY; if idx=3 it SHALL go to DONE.
REQ-020 dut_a and dut_b SHALL remain stable through APPLY and SAMPLE of a vector and SHALL change only on the transition into the next vector's APPLY.
REQ-021 busy SHALL be high in APPLY and SAMPLE, so a valid run keeps busy high for exactly 4*(SETTLE_CYCLES+1) cycles.
REQ-022 DONE SHALL last one cycle, SHALL assert done=1 and pass=(err_count==0), and SHALL then return to IDLE.
REQ-023 err_count, fail_vec and pass SHALL hold their values from DONE until the next accepted start.
REQ-024 start SHALL be ignored while busy=1 or while in DONE.
REQ-025 The op input SHALL be ignored except at the accepted start.
REQ-026 start with op=6 or op=7 SHALL skip testing and go directly to DONE on the next edge with pass=0, err_count=4 and fail_vec=4'hF.
- busy SHALL stay 0 throughout, and dut_a/dut_b SHALL stay 0.
REQ-027 In IDLE and DONE, dut_a and dut_b SHALL be driven 0.
REQ-028 err_count SHALL NOT wrap, since its maximum reachable value is 4.

Reset
REQ-029 rst_n=0 SHALL immediately force the state to IDLE and set idx=0, settle counter=0, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0 and fail_vec=0.
REQ-030 A reset asserted mid-run SHALL abort the run, and no done pulse SHALL follow.
REQ-031 The first start after reset deassertion SHALL be accepted normally.

Verification
REQ-032 Correct AND DUT, op=0, SETTLE_CYCLES=2, start pulsed one cycle -> busy high for 12 cycles, then done=1 for 1 cycle, pass=1, err_count=0, fail_vec=4'b0000.
REQ-033 DUT stuck-at-0, op=0 -> pass=0, err_count=1, fail_vec=4'b1000.
REQ-034 Correct AND DUT, op=3 (NOR) -> pass=0, err_count=2, fail_vec=4'b1001.
REQ-035 Correct AND DUT, op=0, start re-pulsed at the 5th busy cycle -> the second start is ignored, exactly one done pulse occurs, and the results match REQ-032.
REQ-036 op=7 with start -> next cycle done=1, busy never high, pass=0, err_count=4, fail_vec=4'hF.
REQ-037 rst_n driven low during vector 2 (between clock edges) -> all outputs 0 immediately, no done pulse; a following run with a correct AND DUT and op=0 -> pass=1.
